// File: rtl/multicore_system_dpram_ctrl_if.sv
// Bus bundle for the dual-port TCM: port A (s1) and port B (s2) Avalon-style slave signals.
interface multicore_system_dpram_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  chipselect;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic                  clken;
  logic [DATA_WIDTH-1:0] readdata;

  logic [ADDR_WIDTH-1:0] address2;
  logic [BE_WIDTH-1:0]   byteenable2;
  logic                  chipselect2;
  logic                  write2;
  logic [DATA_WIDTH-1:0] writedata2;
  logic                  clken2;
  logic [DATA_WIDTH-1:0] readdata2;

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    input  address2, byteenable2, chipselect2, write2, writedata2, clken2,
    output readdata, readdata2
  );

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    output address2, byteenable2, chipselect2, write2, writedata2, clken2,
    input  readdata, readdata2
  );
endinterface

// File: rtl/multicore_system_dpram_ctrl.sv
// True dual-port TCM with byte enables, clear-on-reset sequencer and write-collision flag.
// Define DPRAM_RDW_BYPASS_EN to return new (merged) data on read-during-write.
module multicore_system_dpram_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned OUTREG         = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reset_req,
  multicore_system_dpram_ctrl_if.slave bus,
  output logic init_busy,
  output logic collision
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} init_state_t;

  init_state_t      state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic             in_rng_a, in_rng_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             wren_a, wren_b, we_a, we_b;
  logic [DATA_WIDTH-1:0] rd_next_a, rd_next_b, rd_q_a, rd_q_b, rd_out_a, rd_out_b;

  assign in_rng_a = 32'(bus.address)  < DEPTH;
  assign in_rng_b = 32'(bus.address2) < DEPTH;
  assign idx_a    = bus.address[IDX_W-1:0];
  assign idx_b    = bus.address2[IDX_W-1:0];

  assign wren_a = bus.chipselect  & bus.write  & bus.clken  & ~reset_req & ~init_busy;
  assign wren_b = bus.chipselect2 & bus.write2 & bus.clken2 & ~reset_req & ~init_busy;
  assign we_a   = wren_a & in_rng_a;
  assign we_b   = wren_b & in_rng_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    init_busy = (state == CLEAR);
    if (state == CLEAR && !reset_req) begin
      if (cnt == LAST_IDX) begin
        state_n = READY;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + IDX_W'(1);
      end
    end
  end

  // Port B lanes are written first so that port A overrides overlapping lanes on a collision.
  always_ff @(posedge clk) begin
    if (!reset && !reset_req) begin
      if (init_busy) begin
        mem[cnt] <= '0;
      end else begin
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
          if (we_b && bus.byteenable2[i]) mem[idx_b][8*i +: 8] <= bus.writedata2[8*i +: 8];
          if (we_a && bus.byteenable[i])  mem[idx_a][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

`ifdef DPRAM_RDW_BYPASS_EN
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wd,
    input logic [BE_WIDTH-1:0]   be
  );
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int unsigned i = 0; i < BE_WIDTH; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction
`endif

  // Synchronous read register captures the pre-write word, giving old-data read-during-write.
  always_comb begin
    rd_next_a = '0;
    rd_next_b = '0;
    if (!init_busy) begin
      if (in_rng_a) rd_next_a = mem[idx_a];
      if (in_rng_b) rd_next_b = mem[idx_b];
`ifdef DPRAM_RDW_BYPASS_EN
      if (in_rng_a && we_b && idx_b == idx_a)
        rd_next_a = merge_lanes(rd_next_a, bus.writedata2, bus.byteenable2);
      if (in_rng_a && we_a)
        rd_next_a = merge_lanes(rd_next_a, bus.writedata, bus.byteenable);
      if (in_rng_b && we_b)
        rd_next_b = merge_lanes(rd_next_b, bus.writedata2, bus.byteenable2);
      if (in_rng_b && we_a && idx_a == idx_b)
        rd_next_b = merge_lanes(rd_next_b, bus.writedata, bus.byteenable);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_a <= '0;
      rd_q_b <= '0;
    end else begin
      if (bus.clken  && !reset_req) rd_q_a <= rd_next_a;
      if (bus.clken2 && !reset_req) rd_q_b <= rd_next_b;
    end
  end

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DATA_WIDTH-1:0] out_a, out_b;
      always_ff @(posedge clk) begin
        if (reset) begin
          out_a <= '0;
          out_b <= '0;
        end else begin
          if (bus.clken  && !reset_req) out_a <= rd_q_a;
          if (bus.clken2 && !reset_req) out_b <= rd_q_b;
        end
      end
      assign rd_out_a = out_a;
      assign rd_out_b = out_b;
    end else begin : g_direct
      assign rd_out_a = rd_q_a;
      assign rd_out_b = rd_q_b;
    end
  endgenerate

  assign bus.readdata  = init_busy ? '0 : rd_out_a;
  assign bus.readdata2 = init_busy ? '0 : rd_out_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      collision <= 1'b0;
    end else if (!reset_req) begin
      collision <= wren_a & wren_b & (bus.address == bus.address2);
    end
  end
endmodule
